// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state encoding, grant constants and FIFO sizing for
// the two-port AXI-Stream write arbiter and its output FIFO.
package axis_arb_pkg;

  // Arbiter states: idle or holding a packet-long grant on one port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_t;

  // One-hot grant values presented on the grant port.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  // Output FIFO sizing; the count needs to represent 0..FIFO_DEPTH.
  localparam int FIFO_DEPTH   = 2;
  localparam int FIFO_COUNT_W = $clog2(FIFO_DEPTH + 1);

  // Map an arbiter state onto its one-hot grant.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      ST_GNT0: return GRANT_0;
      ST_GNT1: return GRANT_1;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// axis_fifo2: two-entry register FIFO for stream beats. Entry slot0 is always
// the head, so the read side is a plain register with no read pointer. The
// head is forced to zero while empty so a flushed FIFO drives quiet outputs.
module axis_fifo2
  import axis_arb_pkg::*;
#(
  parameter int WIDTH = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    head_valid,
  output logic [FIFO_COUNT_W-1:0] count
);

  logic [WIDTH-1:0]        slot0_q;
  logic [WIDTH-1:0]        slot1_q;
  logic [FIFO_COUNT_W-1:0] count_q;
  logic                    full;
  logic                    push_en;
  logic                    pop_en;

  assign full       = (count_q == FIFO_COUNT_W'(FIFO_DEPTH));
  assign head_valid = (count_q != '0);
  assign push_en    = push && !full;
  assign pop_en     = pop && head_valid;
  assign head_data  = head_valid ? slot0_q : '0;
  assign count      = count_q;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register sees pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else if (push_en && !pop_en) begin
      count_q <= count_q + FIFO_COUNT_W'(1);
    end else if (pop_en && !push_en) begin
      count_q <= count_q - FIFO_COUNT_W'(1);
    end
  end

  // Payload slots: pop shifts slot1 forward, push fills the first free slot.
  always_ff @(posedge clk) begin
    // NOTE: the payload slots are deliberately not reset; count_q alone defines
    // which slots hold data, and the head is masked to zero when empty.
    if (pop_en) begin
      if (push_en) begin
        slot0_q <= push_data;        // only possible with one entry held
      end else begin
        slot0_q <= slot1_q;
      end
    end else if (push_en) begin
      if (count_q == '0) begin
        slot0_q <= push_data;
      end else begin
        slot1_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/axis_write_arbiter.sv
// axis_write_arbiter: packet-granular round-robin arbiter that merges two
// AXI-Stream producers onto the single write stream of memory_controller.
// A grant is held from the first beat of a packet until its tlast beat is
// accepted; granted beats are buffered in a two-entry FIFO so the producer
// readies depend only on registers.
module axis_write_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,

  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s00_axis_tstrb,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tlast,
  output logic                  s00_axis_tready,

  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s01_axis_tstrb,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tlast,
  output logic                  s01_axis_tready,

  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic [STRB_WIDTH-1:0] m00_axis_tstrb,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,

  output logic [1:0]            grant
);

  localparam int BEAT_W = DATA_WIDTH + STRB_WIDTH + 1;

  // One stream beat as stored in the FIFO.
  typedef struct packed {
    logic                  last;
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic                    last_grant_q;
  logic                    last_grant_d;

  beat_t                   in0_beat;
  beat_t                   in1_beat;
  beat_t                   push_beat;
  beat_t                   head_beat;
  logic                    push;
  logic                    pop;
  logic                    fifo_valid;
  logic [FIFO_COUNT_W-1:0] fifo_count;
  logic                    fifo_has_room;

  assign in0_beat = '{last: s00_axis_tlast, strb: s00_axis_tstrb, data: s00_axis_tdata};
  assign in1_beat = '{last: s01_axis_tlast, strb: s01_axis_tstrb, data: s01_axis_tdata};

  // Room is judged from the registered count only, which keeps the producer
  // readies free of any combinational path from m00_axis_tready.
  assign fifo_has_room = (fifo_count != FIFO_COUNT_W'(FIFO_DEPTH));
  assign pop           = fifo_valid && m00_axis_tready;

  axis_fifo2 #(
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk        (axis_aclk),
    .rst        (axis_areset),
    .push       (push),
    .push_data  (push_beat),
    .pop        (pop),
    .head_data  (head_beat),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  // Arbiter state and the port that most recently finished a packet.
  // last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state, producer readies and FIFO push selection.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    push            = 1'b0;
    push_beat       = '0;

    case (state_q)
      ST_IDLE: begin
        // Registered decision: the first beat is accepted one cycle later.
        if (s00_axis_tvalid && s01_axis_tvalid) begin
          state_d = last_grant_q ? ST_GNT0 : ST_GNT1;
        end else if (s00_axis_tvalid) begin
          state_d = ST_GNT0;
        end else if (s01_axis_tvalid) begin
          state_d = ST_GNT1;
        end
      end

      ST_GNT0: begin
        s00_axis_tready = fifo_has_room;
        push_beat       = in0_beat;
        if (s00_axis_tvalid && fifo_has_room) begin
          push = 1'b1;
          if (s00_axis_tlast) begin
            // Hand over without a bubble when the other port is waiting.
            last_grant_d = 1'b0;
            state_d      = s01_axis_tvalid ? ST_GNT1 : ST_IDLE;
          end
        end
      end

      ST_GNT1: begin
        s01_axis_tready = fifo_has_room;
        push_beat       = in1_beat;
        if (s01_axis_tvalid && fifo_has_room) begin
          push = 1'b1;
          if (s01_axis_tlast) begin
            last_grant_d = 1'b1;
            state_d      = s00_axis_tvalid ? ST_GNT0 : ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m00_axis_tvalid = fifo_valid;
  assign m00_axis_tdata  = head_beat.data;
  assign m00_axis_tstrb  = head_beat.strb;
  assign m00_axis_tlast  = head_beat.last;
  assign grant           = grant_of(state_q);

endmodule

// File: tb/tb_axis_write_arbiter.sv
// tb_axis_write_arbiter: directed and randomized bench for axis_write_arbiter.
// A queue-based behavioural model predicts grant, readies and the m00 head on
// every cycle; directed scenarios pin the model with hand-computed values and
// a per-port scoreboard checks ordering and packet contiguity under random
// traffic and backpressure.
`timescale 1ns/1ps
module tb_axis_write_arbiter;

  typedef struct packed {
    logic        last;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  logic        axis_aclk = 1'b0;
  logic        axis_areset = 1'b0;
  logic [31:0] s00_axis_tdata = '0;
  logic [3:0]  s00_axis_tstrb = '0;
  logic        s00_axis_tvalid = 1'b0;
  logic        s00_axis_tlast = 1'b0;
  logic        s00_axis_tready;
  logic [31:0] s01_axis_tdata = '0;
  logic [3:0]  s01_axis_tstrb = '0;
  logic        s01_axis_tvalid = 1'b0;
  logic        s01_axis_tlast = 1'b0;
  logic        s01_axis_tready;
  logic [31:0] m00_axis_tdata;
  logic [3:0]  m00_axis_tstrb;
  logic        m00_axis_tvalid;
  logic        m00_axis_tlast;
  logic        m00_axis_tready = 1'b0;
  logic [1:0]  grant;

  axis_write_arbiter #(
    .DATA_WIDTH (32)
  ) dut (
    .axis_aclk       (axis_aclk),
    .axis_areset     (axis_areset),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tready (s01_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .grant           (grant)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_checks = 0;
  int n_errors = 0;
  int gap_pct  = 0;
  int acc0     = 0;
  int acc1     = 0;
  int cyc      = 0;

  beat_t tx0[$];
  beat_t tx1[$];
  beat_t out_q[$];
  int    out_cyc[$];

  // Scoreboard for the random phase.
  bit    sb_en = 1'b0;
  int    cur_src = -1;
  beat_t exp0[$];
  beat_t exp1[$];

  // Behavioural model: owner port (-1 = none), last finisher, buffered beats.
  bit    model_on = 1'b0;
  int    m_own = -1;
  int    m_lastp = 1;
  beat_t mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #2;
  endtask

  task automatic send(input int port, input logic [31:0] d, input logic [3:0] s, input logic l);
    beat_t b;
    b = '{last: l, strb: s, data: d};
    if (port == 0) tx0.push_back(b);
    else tx1.push_back(b);
  endtask

  task automatic do_reset();
    tick();
    tx0.delete();
    tx1.delete();
    axis_areset = 1'b1;
    tick();
    tick();
    axis_areset = 1'b0;
  endtask

  task automatic wait_out(input string name, input int base, input int n, input int budget);
    int k;
    k = 0;
    while (out_q.size() < base + n && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(out_q.size() - base), 64'(n));
  endtask

  // Producer 0: holds a presented beat until accepted, may insert gaps between beats.
  always @(posedge axis_aclk) begin
    logic took;
    took = !axis_areset && s00_axis_tvalid && s00_axis_tready;
    if (took) begin
      acc0++;
      if (tx0.size() > 0) void'(tx0.pop_front());
    end
    #1;
    if (tx0.size() > 0 && ((s00_axis_tvalid && !took) || $urandom_range(0, 99) >= gap_pct)) begin
      s00_axis_tvalid = 1'b1;
      {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata} = tx0[0];
    end else begin
      s00_axis_tvalid = 1'b0;
      {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata} = '0;
    end
  end

  // Producer 1: same behaviour as producer 0.
  always @(posedge axis_aclk) begin
    logic took;
    took = !axis_areset && s01_axis_tvalid && s01_axis_tready;
    if (took) begin
      acc1++;
      if (tx1.size() > 0) void'(tx1.pop_front());
    end
    #1;
    if (tx1.size() > 0 && ((s01_axis_tvalid && !took) || $urandom_range(0, 99) >= gap_pct)) begin
      s01_axis_tvalid = 1'b1;
      {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata} = tx1[0];
    end else begin
      s01_axis_tvalid = 1'b0;
      {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata} = '0;
    end
  end

  // Per-cycle compare against the model, output capture, scoreboard, model advance.
  always @(negedge axis_aclk) begin
    beat_t      got;
    beat_t      want;
    logic [3:0] exp_ctrl;
    logic [37:0] exp_out;
    bit         have;
    bit         a0;
    bit         a1;
    int         src;
    cyc++;

    if (model_on) begin
      exp_ctrl = {m_own == 1, m_own == 0,
                  (m_own == 0) && (mq.size() < 2), (m_own == 1) && (mq.size() < 2)};
      check("ctrl", 64'({grant, s00_axis_tready, s01_axis_tready}), 64'(exp_ctrl));
      exp_out = (mq.size() > 0) ? {1'b1, mq[0]} : '0;
      check("m00", 64'({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata}),
            64'(exp_out));
    end

    if (!axis_areset && m00_axis_tvalid && m00_axis_tready) begin
      got = {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata};
      out_q.push_back(got);
      out_cyc.push_back(cyc);
      if (sb_en) begin
        src = int'(got.data[31]);
        if (src == 0) begin
          have = exp0.size() > 0;
          want = have ? exp0.pop_front() : '0;
        end else begin
          have = exp1.size() > 0;
          want = have ? exp1.pop_front() : '0;
        end
        check("sb_beat", 64'({have, got}), 64'({1'b1, want}));
        if (cur_src >= 0) check("sb_contig", 64'(src), 64'(cur_src));
        cur_src = got.last ? -1 : src;
      end
    end

    if (axis_areset) begin
      m_own    = -1;
      m_lastp  = 1;
      mq.delete();
      cur_src  = -1;
      model_on = 1'b1;
    end else if (model_on) begin
      a0 = (m_own == 0) && (mq.size() < 2) && s00_axis_tvalid;
      a1 = (m_own == 1) && (mq.size() < 2) && s01_axis_tvalid;
      if (mq.size() > 0 && m00_axis_tready) void'(mq.pop_front());
      if (a0) mq.push_back({s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata});
      if (a1) mq.push_back({s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata});
      if (m_own < 0) begin
        if (s00_axis_tvalid && s01_axis_tvalid) m_own = (m_lastp == 1) ? 0 : 1;
        else if (s00_axis_tvalid) m_own = 0;
        else if (s01_axis_tvalid) m_own = 1;
      end else if ((a0 && s00_axis_tlast) || (a1 && s01_axis_tlast)) begin
        m_lastp = m_own;
        if (m_own == 0) m_own = s01_axis_tvalid ? 1 : -1;
        else m_own = s00_axis_tvalid ? 0 : -1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int base_acc;
    int k;
    int n0;
    int total;
    int seq;
    int len;
    logic [31:0] d;
    logic [31:0] e;

    // Reset then idle.
    do_reset();
    m00_axis_tready = 1'b1;
    repeat (10) tick();
    @(negedge axis_aclk);
    check("idle_grant", 64'(grant), 64'(2'b00));
    check("idle_ready", 64'({s00_axis_tready, s01_axis_tready}), 64'(2'b00));
    check("idle_valid", 64'(m00_axis_tvalid), 64'(1'b0));

    // Single-beat packet on s00.
    tick();
    base = out_q.size();
    send(0, 32'h0000_0055, 4'hF, 1'b1);
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    check("single_c0_grant", 64'(grant), 64'(2'b00));
    @(negedge axis_aclk);
    check("single_c1_grant", 64'(grant), 64'(2'b01));
    check("single_c1_ready", 64'(s00_axis_tready), 64'(1'b1));
    @(negedge axis_aclk);
    check("single_c2_m00", 64'({m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata}),
          64'({1'b1, 1'b1, 32'h0000_0055}));
    check("single_c2_grant", 64'(grant), 64'(2'b00));

    // Tie: s00 two beats, s01 one beat, offered together.
    do_reset();
    m00_axis_tready = 1'b1;
    base = out_q.size();
    send(0, 32'h0000_0022, 4'hF, 1'b0);
    send(0, 32'h0000_0024, 4'hF, 1'b1);
    send(1, 32'h0000_0099, 4'hF, 1'b1);
    wait_out("tie_count", base, 3, 40);
    if (out_q.size() >= base + 3) begin
      check("tie_b0", 64'({out_q[base].last, out_q[base].data}), 64'({1'b0, 32'h0022}));
      check("tie_b1", 64'({out_q[base+1].last, out_q[base+1].data}), 64'({1'b1, 32'h0024}));
      check("tie_b2", 64'({out_q[base+2].last, out_q[base+2].data}), 64'({1'b1, 32'h0099}));
      check("tie_gap01", 64'(out_cyc[base+1] - out_cyc[base]), 64'(1));
      check("tie_gap12", 64'(out_cyc[base+2] - out_cyc[base+1]), 64'(1));
    end

    // Fairness: both ports offer ten single-beat packets back to back.
    do_reset();
    m00_axis_tready = 1'b1;
    base = out_q.size();
    for (int i = 0; i < 10; i++) begin
      send(0, 32'h0000_0F00 + 32'(i), 4'hF, 1'b1);
      send(1, 32'h8000_0F00 + 32'(i), 4'hF, 1'b1);
    end
    wait_out("fair_count", base, 20, 120);
    n0 = 0;
    for (int i = 0; i < 20 && base + i < out_q.size(); i++) begin
      e = ((i % 2) == 1) ? 32'h8000_0F00 : 32'h0000_0F00;
      e = e + 32'(i / 2);
      check("fair_beat", 64'(out_q[base+i].data), 64'(e));
      if (out_q[base+i].data[31] == 1'b0) n0++;
    end
    check("fair_port0", 64'(n0), 64'(10));

    // Backpressure: four beats on s01 with the downstream stalled.
    do_reset();
    m00_axis_tready = 1'b0;
    base_acc = acc1;
    base = out_q.size();
    for (int i = 0; i < 4; i++) send(1, 32'h0000_0100 + 32'(i), 4'hA, (i == 3) ? 1'b1 : 1'b0);
    repeat (10) tick();
    check("bp_accepted", 64'(acc1 - base_acc), 64'(2));
    @(negedge axis_aclk);
    check("bp_ready", 64'(s01_axis_tready), 64'(1'b0));
    check("bp_grant", 64'(grant), 64'(2'b10));
    check("bp_head", 64'({m00_axis_tvalid, m00_axis_tstrb, m00_axis_tdata}),
          64'({1'b1, 4'hA, 32'h0000_0100}));
    tick();
    m00_axis_tready = 1'b1;
    wait_out("bp_count", base, 4, 40);
    for (int i = 0; i < 4 && base + i < out_q.size(); i++) begin
      check("bp_beat", 64'({out_q[base+i].last, out_q[base+i].data}),
            64'({(i == 3) ? 1'b1 : 1'b0, 32'h0000_0100 + 32'(i)}));
    end
    check("bp_total", 64'(acc1 - base_acc), 64'(4));

    // Reset mid-packet after a completed s00 packet moved the tie pointer.
    do_reset();
    m00_axis_tready = 1'b1;
    base = out_q.size();
    send(0, 32'h0000_0011, 4'hF, 1'b1);
    wait_out("mid_pre", base, 1, 20);
    repeat (3) tick();
    m00_axis_tready = 1'b0;
    base_acc = acc0;
    base = out_q.size();
    send(0, 32'h0000_0A01, 4'hF, 1'b0);
    send(0, 32'h0000_0A02, 4'hF, 1'b0);
    send(0, 32'h0000_0A03, 4'hF, 1'b1);
    k = 0;
    while (acc0 - base_acc < 2 && k < 20) begin
      tick();
      k++;
    end
    check("mid_accepted", 64'(acc0 - base_acc), 64'(2));
    axis_areset = 1'b1;
    tx0.delete();
    tx1.delete();
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    check("mid_ctrl", 64'({grant, s00_axis_tready, s01_axis_tready}), 64'(4'b0000));
    check("mid_m00", 64'({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata}),
          64'(0));
    check("mid_no_out", 64'(out_q.size() - base), 64'(0));
    tick();
    axis_areset = 1'b0;
    m00_axis_tready = 1'b1;
    base = out_q.size();
    send(0, 32'h0000_0A0A, 4'hF, 1'b1);
    send(1, 32'h0000_0B0B, 4'hF, 1'b1);
    wait_out("mid_post_count", base, 2, 30);
    if (out_q.size() >= base + 2) begin
      check("mid_post_first", 64'(out_q[base].data), 64'(32'h0000_0A0A));
      check("mid_post_second", 64'(out_q[base+1].data), 64'(32'h0000_0B0B));
    end

    // Random traffic with gaps and random downstream backpressure.
    do_reset();
    gap_pct = 30;
    sb_en = 1'b1;
    base = out_q.size();
    total = 0;
    seq = 0;
    for (int p = 0; p < 2; p++) begin
      for (int pk = 0; pk < 30; pk++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          d = {p[0], 15'(seq), 16'($urandom)};
          seq++;
          send(p, d, 4'($urandom), (j == len - 1) ? 1'b1 : 1'b0);
          if (p == 0) exp0.push_back({(j == len - 1) ? 1'b1 : 1'b0, tx0[tx0.size()-1].strb, d});
          else exp1.push_back({(j == len - 1) ? 1'b1 : 1'b0, tx1[tx1.size()-1].strb, d});
          total++;
        end
      end
    end
    k = 0;
    while ((exp0.size() + exp1.size()) > 0 && k < 6000) begin
      tick();
      m00_axis_tready = ($urandom_range(0, 3) != 0);
      k++;
    end
    check("rand_drain", 64'(exp0.size() + exp1.size()), 64'(0));
    check("rand_count", 64'(out_q.size() - base), 64'(total));
    sb_en = 1'b0;
    gap_pct = 0;
    m00_axis_tready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_write_arbiter.md
# axis_write_arbiter

- Two-input AXI-Stream arbiter that shares the single write port (`s01_axis_*`) of `memory_controller` between two producers.
- Packet-granular round-robin: a grant is held from the first beat of a packet until its `tlast` beat is accepted.
- Granted beats pass through a 2-entry output FIFO, which registers the downstream handshake without losing throughput.
- Sits directly upstream of `memory_controller` and drives its write stream.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: stream data width, must match `memory_controller`.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: strobe width.

Ports:
- `axis_aclk`  in  1  single clock for all ports.
- `axis_areset`  in  1  reset, synchronous, active-high.
- `s00_axis_tdata`  in  `DATA_WIDTH`  requester 0 data.
- `s00_axis_tstrb`  in  `STRB_WIDTH`  requester 0 strobe.
- `s00_axis_tvalid`  in  1  requester 0 valid.
- `s00_axis_tlast`  in  1  requester 0 end of packet.
- `s00_axis_tready`  out  1  requester 0 ready.
- `s01_axis_tdata`, `s01_axis_tstrb`, `s01_axis_tvalid`, `s01_axis_tlast`, `s01_axis_tready`: requester 1, same widths and directions as requester 0.
- `m00_axis_tdata`  out  `DATA_WIDTH`  to `memory_controller` `s01_axis_tdata`.
- `m00_axis_tstrb`  out  `STRB_WIDTH`  forwarded strobe.
- `m00_axis_tvalid`  out  1  forwarded valid.
- `m00_axis_tlast`  out  1  forwarded end of packet.
- `m00_axis_tready`  in  1  from `memory_controller` `s01_axis_tready`.
- `grant`  out  2  one-hot current grant; 2'b00 when idle.

## Operation
State machine states: IDLE, GNT0, GNT1.

IDLE:
- If only one `sN_axis_tvalid` is high, go to GNTN.
- If both are high, grant the port opposite `last_grant`.
- The arbitration decision is registered, so one bubble cycle precedes the first beat of each packet.

GNTN:
- `sN_axis_tready = (fifo_count != 2)`. The non-granted ready is 0.
- A beat is accepted when `sN_axis_tvalid && sN_axis_tready`. `{tdata, tstrb, tlast}` is pushed into the FIFO.
- When the accepted beat has `tlast=1`:
  - `last_grant <= N`.
  - If the other port's `tvalid` is high in the same cycle, go directly to its grant state (no bubble).
  - Otherwise go to IDLE.
- `tvalid` on the granted port dropping mid-packet does not release the grant. The arbiter waits.

Output FIFO, 2 entries:
- `m00_axis_tvalid = (fifo_count != 0)`; data, strobe and last come from the head entry.
- A pop occurs on `m00_axis_tvalid && m00_axis_tready`.
- Push and pop in the same cycle leave the count unchanged.
- `sN_axis_tready` depends only on registers, so there is no combinational path from `m00_axis_tready`.

Other rules:
- Beats are forwarded unmodified; no width conversion and no strobe interpretation.
- Packets are never interleaved on `m00`: all beats of one packet appear contiguously.

## Timing
Reset (synchronous, active-high):
- State IDLE, `last_grant = 1` (port 0 wins the first tie), FIFO empty.
- All outputs are 0: `s00_axis_tready`, `s01_axis_tready`, `m00_axis_tvalid`, `m00_axis_tdata`, `m00_axis_tstrb`, `m00_axis_tlast`, `grant`.

Latency:
- Input acceptance to `m00_axis_tvalid` is 1 cycle.
- Arbitration from IDLE adds 1 cycle.
- Sustained throughput is 1 beat/cycle while `m00_axis_tready` is held high.

Backpressure:
- With `m00_axis_tready=0` the FIFO fills to 2 entries and the granted ready drops in the cycle after the second push.
- Neither the FIFO nor `grant` changes while stalled.

Reset mid-packet:
- The FIFO is flushed and the partial packet is dropped. The downstream never sees its `tlast`.
- Producers restart the packet after reset.

## Structure
- Package `axis_arb_pkg`: state encodings (`ST_IDLE`, `ST_GNT0`, `ST_GNT1`), grant one-hot constants, `FIFO_DEPTH = 2`.
- Sub-module `axis_fifo2`:
  - 2-entry register FIFO with push/pop/count.
  - Carries `{tlast, tstrb, tdata}`.
  - Reusable for other stream stages.
- The top level holds the FSM, `last_grant` and the ready/mux logic.

## Test plan
- Reset then idle: no `tvalid` for 10 cycles -> `grant=0`, both readies 0, `m00_axis_tvalid=0`.
- Single-beat packet on s00 (`tdata=32'h0055`, `tstrb=4'hF`, `tlast=1`) -> `grant=2'b01` on cycle 1; `m00` shows `32'h0055`, `tlast=1` on cycle 2; back to IDLE.
- Tie:
  - Stimulus: s00 sends a 2-beat packet (`32'h0022`, `32'h0024`) and s01 sends a 1-beat packet (`32'h0099`), both valid from the same cycle.
  - Required: s00 is served first, then s01 with no bubble.
  - `m00` sequence: `0022`, `0024`, `0099`; `tlast` set on `0024` and on `0099` only.
- Fairness: both ports continuously offer 1-beat packets for 20 packets -> `m00` alternates 0,1,0,1..., 10 packets from each port.
- Backpressure:
  - `m00_axis_tready=0` while s01 streams 4 beats -> exactly 2 beats are accepted and `s01_axis_tready` drops.
  - After `tready` returns to 1: all 4 beats are delivered in order, with no loss or duplication.
- Reset mid-packet: assert `axis_areset` after the 2nd of 3 beats -> outputs are 0 the next cycle, the FIFO is empty, and the next packet arbitrates from IDLE with port 0 priority.
